// File: rtl/comparator_msb_serial.sv
`default_nettype none
// ============================================================================
// Module      : comparator_msb_serial
// Description : Multi-cycle MSB-first chunked magnitude comparator for signed
//               or unsigned operands. The scan starts at the top chunk and
//               stops at the first chunk that differs, producing eq / lt / ge
//               behind valid/ready handshakes on both sides.
//               Optional feature macro: CMP_MINMAX_EN. When it is defined,
//               registered min_o / max_o outputs are added.
// Revision    : 1.0 - initial release
// ============================================================================
module comparator_msb_serial #(
  parameter int WIDTH = 64,  // operand width in bits
  parameter int CHUNK = 8    // bits compared per cycle, must divide WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             lt,
  output logic             ge
`ifdef CMP_MINMAX_EN
  ,
  output logic [WIDTH-1:0] min_o,
  output logic [WIDTH-1:0] max_o
`endif
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int NCHUNK = WIDTH / CHUNK;
  // A single-chunk configuration still needs a one-bit index to stay legal.
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(NCHUNK - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  // XOR mask that flips the sign bit of a chunk (bias trick for signed data).
  localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

  // FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [1:0]       state;
  logic [1:0]       state_next;

  logic [WIDTH-1:0] op_a;       // operand A captured on the accept edge
  logic [WIDTH-1:0] op_b;       // operand B captured on the accept edge
  logic             op_signed;  // compare mode captured on the accept edge
  logic [IDX_W-1:0] idx;        // chunk currently under comparison

  logic             res_eq;
  logic             res_lt;
  logic             res_ge;

  // --------------------------------------------------------------------------
  // Chunk view of the captured operands
  // --------------------------------------------------------------------------
  logic [CHUNK-1:0] a_chunks [NCHUNK];
  logic [CHUNK-1:0] b_chunks [NCHUNK];

  generate
    for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
      assign a_chunks[g] = op_a[g*CHUNK +: CHUNK];
      assign b_chunks[g] = op_b[g*CHUNK +: CHUNK];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Per-cycle chunk comparison
  // --------------------------------------------------------------------------
  logic             bias;        // flip sign bits on the top chunk of a signed compare
  logic [CHUNK-1:0] cur_a;
  logic [CHUNK-1:0] cur_b;
  logic             chunk_diff;
  logic             chunk_lt;
  logic             last_chunk;
  logic             scan_end;    // this SCAN cycle resolves the result
  logic             accept;      // operands taken on this edge

  // Select the active chunk pair and compare it as unsigned values.
  always_comb begin
    bias       = op_signed && (idx == TOP_IDX);
    cur_a      = a_chunks[idx] ^ (bias ? MSB_MASK : '0);
    cur_b      = b_chunks[idx] ^ (bias ? MSB_MASK : '0);
    chunk_diff = (cur_a != cur_b);
    chunk_lt   = (cur_a < cur_b);
    last_chunk = (idx == '0);
    scan_end   = (state == S_SCAN) && (chunk_diff || last_chunk);
    accept     = in_valid && in_ready;
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------

  // State register; reset aborts any scan in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> SCAN on accept, SCAN -> DONE on resolution,
  // DONE -> IDLE once the consumer takes the result.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        if (chunk_diff || last_chunk) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from the state; DONE never accepts new input.
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------

  // Operands are sampled only on the accept edge and ignored afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
    end else if (accept) begin
      op_a      <= a;
      op_b      <= b;
      op_signed <= is_signed;
    end
  end

  // Chunk index: loads the top chunk on accept and steps down only while the
  // scanned chunks match and chunk 0 has not yet been reached, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (accept) begin
      idx <= TOP_IDX;
    end else if ((state == S_SCAN) && !chunk_diff && !last_chunk) begin
      idx <= idx - IDX_ONE;
    end
  end

  // Result flags load once per operation, so they stay frozen through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_eq <= 1'b0;
      res_lt <= 1'b0;
      res_ge <= 1'b0;
    end else if (scan_end) begin
      res_eq <= !chunk_diff;
      res_lt <= chunk_diff && chunk_lt;
      res_ge <= !(chunk_diff && chunk_lt);
    end
  end

  assign eq = res_eq;
  assign lt = res_lt;
  assign ge = res_ge;

`ifdef CMP_MINMAX_EN
  logic [WIDTH-1:0] res_min;
  logic [WIDTH-1:0] res_max;

  // Min/max select loads alongside the flags; equal operands yield A for both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_min <= '0;
      res_max <= '0;
    end else if (scan_end) begin
      res_min <= (chunk_diff && chunk_lt) ? op_a : op_b;
      res_max <= (chunk_diff && chunk_lt) ? op_b : op_a;
    end
  end

  assign min_o = res_min;
  assign max_o = res_max;
`else
  // Without min/max the comparator carries only the eq/lt/ge flags.
`endif

endmodule
`default_nettype wire

// File: tb/tb_comparator_msb_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_comparator_msb_serial
// Description : Self-checking bench for comparator_msb_serial: directed
//               vector table, reset/back-pressure sequences and a signed
//               sweep over small sign-extended values. Also covers min_o /
//               max_o when CMP_MINMAX_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comparator_msb_serial;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic        eq;
  logic        lt;
  logic        ge;
`ifdef CMP_MINMAX_EN
  logic [63:0] min_o;
  logic [63:0] max_o;
`endif

  int checks   = 0;
  int failures = 0;

  comparator_msb_serial #(.WIDTH(64), .CHUNK(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .eq        (eq),
    .lt        (lt),
    .ge        (ge)
`ifdef CMP_MINMAX_EN
    ,
    .min_o     (min_o),
    .max_o     (max_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so the run always ends.
  initial begin
    #5000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Runs one operation starting at a negedge in IDLE; returns at a negedge
  // after the result was taken. Inputs are scrambled right after accept.
  task automatic run_op(input logic [63:0] va, input logic [63:0] vb, input logic vs,
                        output int lat, output logic r_eq, output logic r_lt,
                        output logic r_ge, output logic [63:0] r_min,
                        output logic [63:0] r_max);
    a         = va;
    b         = vb;
    is_signed = vs;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    a         = vb;
    b         = va;
    is_signed = ~vs;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    r_eq = eq;
    r_lt = lt;
    r_ge = ge;
`ifdef CMP_MINMAX_EN
    r_min = min_o;
    r_max = max_o;
`else
    r_min = '0;
    r_max = '0;
`endif
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_out_valid", 64'(out_valid), 64'd0);
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        s;
    logic        eq;
    logic        lt;
    int          lat;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int          lat;
    logic        r_eq, r_lt, r_ge;
    logic [63:0] r_min, r_max;
    logic [4:0]  snap;
    bit          stale;
    int          vals [15];

    tbl[0]  = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1};
    tbl[1]  = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1};
    tbl[2]  = '{64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b1, 1'b0, 8};
    tbl[3]  = '{64'h0000_0100_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 3};
    tbl[4]  = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 1'b1, 8};
    tbl[5]  = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 8};
    tbl[6]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1};
    tbl[7]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1};
    tbl[8]  = '{64'hFFFF_FFFF_FFFF_FF00, 64'hFFFF_FFFF_FFFF_FF01, 1'b1, 1'b0, 1'b1, 8};
    tbl[9]  = '{64'h1234_5600_0000_0000, 64'h1234_5500_0000_0000, 1'b1, 1'b0, 1'b0, 3};
    tbl[10] = '{64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b1, 1'b0, 8};
    tbl[11] = '{64'h0000_0000_0080_0000, 64'h0000_0000_007F_FFFF, 1'b1, 1'b0, 1'b0, 6};

    vals = '{-128, -127, -100, -65, -64, -2, -1, 0, 1, 2, 63, 64, 99, 126, 127};

    // ---------------- reset state ----------------
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    is_signed = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_eq",        64'(eq),        64'd0);
    chk("rst_lt",        64'(lt),        64'd0);
    chk("rst_ge",        64'(ge),        64'd0);
`ifdef CMP_MINMAX_EN
    chk("rst_min", min_o, 64'd0);
    chk("rst_max", max_o, 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- directed table ----------------
    for (int k = 0; k < 12; k++) begin
      run_op(tbl[k].a, tbl[k].b, tbl[k].s, lat, r_eq, r_lt, r_ge, r_min, r_max);
      chk($sformatf("vec%0d_eq", k),  64'(r_eq), 64'(tbl[k].eq));
      chk($sformatf("vec%0d_lt", k),  64'(r_lt), 64'(tbl[k].lt));
      chk($sformatf("vec%0d_ge", k),  64'(r_ge), 64'(!tbl[k].lt));
      chk($sformatf("vec%0d_lat", k), 64'(lat),  64'(tbl[k].lat));
`ifdef CMP_MINMAX_EN
      chk($sformatf("vec%0d_min", k), r_min, tbl[k].lt ? tbl[k].a : tbl[k].b);
      chk($sformatf("vec%0d_max", k), r_max, tbl[k].lt ? tbl[k].b : tbl[k].a);
`endif
    end

    // ---------------- back-pressure ----------------
    a         = 64'h8000_0000_0000_0000;
    b         = 64'h7FFF_FFFF_FFFF_FFFF;
    is_signed = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    // keep offering different operands; they must not be taken before IDLE
    a         = 64'h0;
    b         = 64'h0;
    is_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    snap = {out_valid, in_ready, eq, lt, ge};
    chk("bp_first", 64'(snap), 64'(5'b10010));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp_hold%0d", c), 64'({out_valid, in_ready, eq, lt, ge}), 64'(5'b10010));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_ready", 64'(in_ready),  64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_no_accept_in_done", 64'(in_ready), 64'd1);

    // ---------------- reset mid-scan ----------------
    a         = 64'hDEAD_BEEF_0123_4567;
    b         = 64'hDEAD_BEEF_0123_4567;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_scan_busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_in_ready",  64'(in_ready),  64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_flags",     64'({eq, lt, ge}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    chk("midrst_no_stale", 64'(stale), 64'd0);
    chk("midrst_idle", 64'(in_ready), 64'd1);

    // ---------------- signed sweep of small values ----------------
    for (int i = 0; i < 15; i++) begin
      for (int j = 0; j < 15; j++) begin
        longint vi, vj, mn, mx;
        int     elat;
        vi   = vals[i];
        vj   = vals[j];
        mn   = (vi < vj) ? vi : vj;
        mx   = (vi < vj) ? vj : vi;
        elat = ((vi < 0) == (vj < 0)) ? 8 : 1;
        run_op(64'(vi), 64'(vj), 1'b1, lat, r_eq, r_lt, r_ge, r_min, r_max);
        chk($sformatf("sw_%0d_%0d_lt", vi, vj),  64'(r_lt), 64'(vi < vj));
        chk($sformatf("sw_%0d_%0d_eq", vi, vj),  64'(r_eq), 64'(vi == vj));
        chk($sformatf("sw_%0d_%0d_ge", vi, vj),  64'(r_ge), 64'(vi >= vj));
        chk($sformatf("sw_%0d_%0d_lat", vi, vj), 64'(lat),  64'(elat));
`ifdef CMP_MINMAX_EN
        chk($sformatf("sw_%0d_%0d_min", vi, vj), r_min, 64'(mn));
        chk($sformatf("sw_%0d_%0d_max", vi, vj), r_max, 64'(mx));
`endif
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
